// File: rtl/timer_reloader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_reloader_if : valid/ready memory bus, initiator <-> responder  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface timer_reloader_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/timer_reloader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_reloader : services the timer interrupt by rewriting compare   |
// | as time + period over the memory bus.                   rev 1.0      |
// +----------------------------------------------------------------------+
module timer_reloader #(
  parameter logic [31:0] BASE    = 32'h0,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [31:0]      period,
  input  logic             timer_irpt,
  timer_reloader_if.master bus,
  output logic             busy,
  output logic             tick,
  output logic             err
);

  localparam logic [3:0] c_st_idle      = 4'd0;
  localparam logic [3:0] c_st_rd_hi1    = 4'd1;
  localparam logic [3:0] c_st_rd_lo     = 4'd2;
  localparam logic [3:0] c_st_rd_hi2    = 4'd3;
  localparam logic [3:0] c_st_wr_hi_max = 4'd4;
  localparam logic [3:0] c_st_wr_lo     = 4'd5;
  localparam logic [3:0] c_st_wr_hi     = 4'd6;
  localparam logic [3:0] c_st_done      = 4'd7;
  localparam logic [3:0] c_st_hold      = 4'd8;

  localparam logic [15:0] c_tmo_last  = 16'(TIMEOUT - 1);
  localparam logic [1:0]  c_max_retry = 2'd3;

  logic [3:0]  state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        gap_q, gap_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] p_q, p_d;
  logic [31:0] h1_q, h1_d;
  logic [31:0] l_q, l_d;
  logic [63:0] n_q, n_d;
  logic [1:0]  retry_q, retry_d;
  logic        hold_q, hold_d;
  logic        err_q, err_d;
  logic        beat_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_st_idle;
      valid_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      gap_q   <= 1'b0;
      tmo_q   <= 16'h0;
      p_q     <= 32'h0;
      h1_q    <= 32'h0;
      l_q     <= 32'h0;
      n_q     <= 64'h0;
      retry_q <= 2'd0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      p_q     <= p_d;
      h1_q    <= h1_d;
      l_q     <= l_d;
      n_q     <= n_d;
      retry_q <= retry_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    gap_d      = 1'b0;
    tmo_d      = tmo_q;
    p_d        = p_q;
    h1_d       = h1_q;
    l_d        = l_q;
    n_d        = n_q;
    retry_d    = retry_q;
    hold_d     = hold_q;
    err_d      = err_q;
    beat_start = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (enable && timer_irpt && !err_q) begin
          state_d    = c_st_rd_hi1;
          p_d        = period;
          retry_d    = 2'd0;
          beat_start = 1'b1;
        end
      end
      c_st_done: begin
        state_d = c_st_hold;
        hold_d  = 1'b0;
      end
      c_st_hold: begin
        if (hold_q) state_d = c_st_idle;
        else        hold_d  = 1'b1;
      end
      c_st_rd_hi1, c_st_rd_lo, c_st_rd_hi2,
      c_st_wr_hi_max, c_st_wr_lo, c_st_wr_hi: begin
        // ready is deliberately not looked at during the gap cycle
        if (gap_q) begin
          beat_start = 1'b1;
        end else if (valid_q) begin
          if (bus.mem_ready) begin
            valid_d = 1'b0;
            tmo_d   = 16'h0;
            gap_d   = 1'b1;
            case (state_q)
              c_st_rd_hi1: begin
                h1_d    = bus.mem_rdata;
                state_d = c_st_rd_lo;
              end
              c_st_rd_lo: begin
                l_d     = bus.mem_rdata;
                state_d = c_st_rd_hi2;
              end
              c_st_rd_hi2: begin
                h1_d = bus.mem_rdata;
                if (bus.mem_rdata != h1_q && retry_q != c_max_retry) begin
                  retry_d = retry_q + 2'd1;
                  state_d = c_st_rd_lo;
                end else begin
                  n_d     = {bus.mem_rdata, l_q} + {32'h0, p_q};
                  state_d = c_st_wr_hi_max;
                end
              end
              c_st_wr_hi_max: state_d = c_st_wr_lo;
              c_st_wr_lo:     state_d = c_st_wr_hi;
              default:        state_d = c_st_done;
            endcase
          end else if (tmo_q == c_tmo_last) begin
            valid_d = 1'b0;
            tmo_d   = 16'h0;
            err_d   = 1'b1;
            state_d = c_st_idle;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end else begin
          state_d = c_st_idle;
        end
      end
      default: state_d = c_st_idle;
    endcase

    if (beat_start && enable) begin
      valid_d = 1'b1;
      tmo_d   = 16'h0;
      wdata_d = 32'h0;
      wstrb_d = 4'h0;
      case (state_d)
        c_st_rd_hi1, c_st_rd_hi2: addr_d = BASE + 32'd12;
        c_st_rd_lo:               addr_d = BASE + 32'd8;
        c_st_wr_hi_max: begin
          addr_d  = BASE + 32'd4;
          wdata_d = 32'hFFFF_FFFF;
          wstrb_d = 4'hF;
        end
        c_st_wr_lo: begin
          addr_d  = BASE;
          wdata_d = n_q[31:0];
          wstrb_d = 4'hF;
        end
        c_st_wr_hi: begin
          addr_d  = BASE + 32'd4;
          wdata_d = n_q[63:32];
          wstrb_d = 4'hF;
        end
        default: valid_d = 1'b0;
      endcase
    end

    // Disable only takes effect once no beat is outstanding on the bus
    if (!enable) begin
      err_d = 1'b0;
      if (!valid_d) begin
        state_d = c_st_idle;
        gap_d   = 1'b0;
        hold_d  = 1'b0;
      end
    end
  end

  always_comb begin
    busy = (state_q != c_st_idle);
    tick = (state_q == c_st_done);
    err  = err_q;
  end

  assign bus.mem_valid = valid_q;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_reloader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_timer_reloader : directed bench with a scripted timer responder   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_timer_reloader;

  localparam logic [31:0] c_base = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] period;
  logic        timer_irpt;
  logic        busy, tick, err;

  timer_reloader_if bus_if ();

  timer_reloader #(.BASE(c_base), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .period     (period),
    .timer_irpt (timer_irpt),
    .bus        (bus_if),
    .busy       (busy),
    .tick       (tick),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder: ready one cycle after valid, optional stale ready in the gap
  bit          resp_en = 1'b1;
  bit          stale   = 1'b0;
  logic [31:0] rd_script [16];
  int          rd_cnt   = 0;
  int          rd_wr    = 0;
  logic [67:0] blog [$];
  int          tick_cnt = 0;
  int          vcnt     = 0;

  always @(posedge clk) begin
    if (tick) tick_cnt <= tick_cnt + 1;
    if (bus_if.mem_valid) vcnt <= vcnt + 1;
    if (!rst) begin
      bus_if.mem_ready <= 1'b0;
    end else if (bus_if.mem_valid && bus_if.mem_ready) begin
      blog.push_back({bus_if.mem_addr, bus_if.mem_wdata, bus_if.mem_wstrb});
      bus_if.mem_ready <= stale;
    end else if (bus_if.mem_valid && resp_en) begin
      bus_if.mem_ready <= 1'b1;
      if (bus_if.mem_wstrb == 4'h0) begin
        bus_if.mem_rdata <= rd_script[rd_cnt & 15];
        rd_cnt <= rd_cnt + 1;
      end else begin
        bus_if.mem_rdata <= 32'hDEAD_BEEF;
      end
    end else begin
      bus_if.mem_ready <= 1'b0;
    end
  end

  logic [67:0] exp_q [$];
  int          log_base;
  int          tick_base;

  task automatic prep();
    exp_q.delete();
    log_base  = blog.size();
    tick_base = tick_cnt;
    rd_wr     = rd_cnt;
  endtask

  task automatic push_rd(input logic [31:0] v);
    rd_script[rd_wr & 15] = v;
    rd_wr++;
  endtask

  task automatic exp_rd(input logic [31:0] off);
    exp_q.push_back({c_base + off, 32'h0, 4'h0});
  endtask

  task automatic exp_wr(input logic [31:0] off, input logic [31:0] d);
    exp_q.push_back({c_base + off, d, 4'hF});
  endtask

  task automatic wait_busy(input logic lvl, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_seq(input string tag);
    bit ok;
    timer_irpt = 1'b1;
    wait_busy(1'b1, 20, ok);
    check_val({tag, "_start"}, 72'(ok), 72'd1);
    timer_irpt = 1'b0;
    wait_busy(1'b0, 200, ok);
    check_val({tag, "_end"}, 72'(ok), 72'd1);
  endtask

  task automatic check_log(input string tag);
    int n;
    n = blog.size() - log_base;
    check_val({tag, "_beats"}, 72'(n), 72'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check_val($sformatf("%s_beat%0d", tag, i), 72'(blog[log_base + i]), 72'(exp_q[i]));
  endtask

  task automatic do_reload(input string tag, input logic [31:0] per,
                           input logic [31:0] hi, input logic [31:0] lo,
                           input logic [31:0] n_lo, input logic [31:0] n_hi);
    prep();
    period = per;
    push_rd(hi); push_rd(lo); push_rd(hi);
    exp_rd(32'd12); exp_rd(32'd8); exp_rd(32'd12);
    exp_wr(32'd4, 32'hFFFF_FFFF); exp_wr(32'd0, n_lo); exp_wr(32'd4, n_hi);
    run_seq(tag);
    check_log(tag);
    check_val({tag, "_ticks"}, 72'(tick_cnt - tick_base), 72'd1);
    check_val({tag, "_err"}, 72'(err), 72'd0);
  endtask

  initial begin
    bit ok;
    int vbase;
    rst        = 1'b0;
    enable     = 1'b1;
    period     = 32'h0;
    timer_irpt = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 72'(bus_if.mem_valid), 72'd0);
    check_val("rst_addr",  72'(bus_if.mem_addr),  72'd0);
    check_val("rst_wdata", 72'(bus_if.mem_wdata), 72'd0);
    check_val("rst_wstrb", 72'(bus_if.mem_wstrb), 72'd0);
    check_val("rst_instr", 72'(bus_if.mem_instr), 72'd0);
    check_val("rst_busy",  72'(busy), 72'd0);
    check_val("rst_tick",  72'(tick), 72'd0);
    check_val("rst_err",   72'(err),  72'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("post_rst_busy",  72'(busy), 72'd0);
    check_val("post_rst_valid", 72'(bus_if.mem_valid), 72'd0);

    do_reload("basic", 32'h40, 32'h0, 32'h100,       32'h0000_0140, 32'h0);
    do_reload("carry", 32'h20, 32'h5, 32'hFFFF_FFF0, 32'h0000_0010, 32'h6);
    do_reload("wrap",  32'h20, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h0000_0010, 32'h0);

    // Hi word changes between the two hi reads: lo is re-read once
    prep();
    period = 32'h10;
    push_rd(32'h1); push_rd(32'h50); push_rd(32'h2); push_rd(32'h60); push_rd(32'h2);
    exp_rd(32'd12); exp_rd(32'd8); exp_rd(32'd12); exp_rd(32'd8); exp_rd(32'd12);
    exp_wr(32'd4, 32'hFFFF_FFFF); exp_wr(32'd0, 32'h70); exp_wr(32'd4, 32'h2);
    run_seq("race");
    check_log("race");
    check_val("race_ticks", 72'(tick_cnt - tick_base), 72'd1);

    stale = 1'b1;
    do_reload("stale", 32'h40, 32'h0, 32'h100, 32'h0000_0140, 32'h0);
    stale = 1'b0;

    // No ready at all: valid must stay up exactly TIMEOUT cycles
    prep();
    resp_en = 1'b0;
    vbase = vcnt;
    run_seq("tmo");
    check_val("tmo_valid_cycles", 72'(vcnt - vbase), 72'd8);
    check_val("tmo_err",   72'(err), 72'd1);
    check_val("tmo_ticks", 72'(tick_cnt - tick_base), 72'd0);
    check_log("tmo");
    timer_irpt = 1'b1;
    vbase = vcnt;
    repeat (10) @(negedge clk);
    check_val("tmo_blocked_busy",  72'(busy), 72'd0);
    check_val("tmo_blocked_valid", 72'(vcnt - vbase), 72'd0);
    check_val("tmo_err_sticky",    72'(err), 72'd1);
    enable = 1'b0;
    @(negedge clk);
    check_val("tmo_err_clear", 72'(err), 72'd0);
    check_val("tmo_dis_busy",  72'(busy), 72'd0);
    enable  = 1'b1;
    resp_en = 1'b1;
    do_reload("recover", 32'h40, 32'h0, 32'h100, 32'h0000_0140, 32'h0);

    // Disable after the first beat: no more beats, no tick
    prep();
    period = 32'h40;
    push_rd(32'h0); push_rd(32'h100); push_rd(32'h0);
    timer_irpt = 1'b1;
    wait_busy(1'b1, 20, ok);
    check_val("dis_start", 72'(ok), 72'd1);
    timer_irpt = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (blog.size() - log_base >= 1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("dis_first_beat", 72'(ok), 72'd1);
    enable = 1'b0;
    wait_busy(1'b0, 20, ok);
    check_val("dis_end", 72'(ok), 72'd1);
    check_val("dis_beats", 72'(blog.size() - log_base), 72'd1);
    check_val("dis_ticks", 72'(tick_cnt - tick_base), 72'd0);
    enable = 1'b1;
    @(negedge clk);

    // Reset while a beat is pending drops valid without a clock edge
    prep();
    resp_en = 1'b0;
    timer_irpt = 1'b1;
    wait_busy(1'b1, 20, ok);
    check_val("arst_start", 72'(bus_if.mem_valid), 72'd1);
    #1 rst = 1'b0;
    #1;
    check_val("arst_valid", 72'(bus_if.mem_valid), 72'd0);
    check_val("arst_busy",  72'(busy), 72'd0);
    timer_irpt = 1'b0;
    resp_en    = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
